cnn_result_streamer: RTL and testbench

- Read-side end of the convolution engine's output buffer. The convolution controller writes the output feature map and pulses done; this block then reads the map in row-major order.
- Each element goes out on a valid/ready stream toward the host/DMA, with end-of-row and end-of-frame markers.
- Read port: synchronous RAM, 1-cycle read latency.

---
 rtl/cnn_pkg.sv | 23 ++
 rtl/cnn_result_streamer_if.sv | 27 ++
 rtl/cnn_rc_counter.sv | 47 ++++
 rtl/cnn_result_streamer.sv | 127 ++++++++++++
 tb/tb_cnn_result_streamer.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN output path: the streamer FSM encoding
// and the default output-map geometry used by the conv controller and result buffer.
package cnn_pkg;

  localparam int CNN_DATA_W   = 16;
  localparam int CNN_OUT_ROWS = 4;
  localparam int CNN_OUT_COLS = 4;
  localparam int CNN_ADDR_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_LAT  = 3'd2,
    ST_SEND = 3'd3,
    ST_FIN  = 3'd4
  } stream_state_e;

  // Counter width for a 0..n-1 range; a 1-entry range still needs one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cnn_result_streamer_if.sv
// Result-buffer read port plus outgoing element stream of the result streamer.
interface cnn_result_streamer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic              start;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_eol;
  logic              m_last;
  logic              busy;
  logic              frame_done;

  modport master (
    input  start, rd_data, m_ready,
    output rd_en, rd_addr, m_valid, m_data, m_eol, m_last, busy, frame_done
  );

  modport slave (
    output start, rd_data, m_ready,
    input  rd_en, rd_addr, m_valid, m_data, m_eol, m_last, busy, frame_done
  );
endinterface

// File: rtl/cnn_rc_counter.sv
// Row/column wrap counter walking a ROWS x COLS map in row-major order.
module cnn_rc_counter
  import cnn_pkg::*;
#(
  parameter int ROWS = CNN_OUT_ROWS,
  parameter int COLS = CNN_OUT_COLS,
  localparam int ROW_W = cnt_w(ROWS),
  localparam int COL_W = cnt_w(COLS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             adv_i,
  output logic [ROW_W-1:0] row_o,
  output logic [COL_W-1:0] col_o,
  output logic             last_col_o,
  output logic             last_all_o
);

  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;
  logic             last_row;

  assign last_row   = (row_q == ROW_W'(ROWS - 1));
  assign last_col_o = (col_q == COL_W'(COLS - 1));
  assign last_all_o = last_row & last_col_o;
  assign row_o      = row_q;
  assign col_o      = col_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else if (clr_i) begin
      row_q <= '0;
      col_q <= '0;
    end else if (adv_i) begin
      if (last_col_o) begin
        col_q <= '0;
        row_q <= last_row ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cnn_result_streamer.sv
// Reads the finished output feature map from the result buffer in row-major order
// and emits it as a valid/ready stream with end-of-row and end-of-frame markers.
module cnn_result_streamer
  import cnn_pkg::*;
#(
  parameter int DATA_W   = CNN_DATA_W,
  parameter int OUT_ROWS = CNN_OUT_ROWS,
  parameter int OUT_COLS = CNN_OUT_COLS,
  parameter int ADDR_W   = CNN_ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  cnn_result_streamer_if.master   bus
);

  localparam int ROW_W = cnt_w(OUT_ROWS);
  localparam int COL_W = cnt_w(OUT_COLS);

  stream_state_e     state_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [DATA_W-1:0] data_q;
  logic              m_valid_q;
  logic              m_eol_q;
  logic              m_last_q;
  logic              busy_q;
  logic              frame_done_q;

  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic              last_col;
  logic              last_all;
  logic              handshake;
  logic              cnt_clr;
  logic              cnt_adv;
  logic [ADDR_W-1:0] addr_cur;
  logic [ADDR_W-1:0] addr_d;

  assign handshake = (state_q == ST_SEND) && bus.m_ready;
  assign cnt_clr   = ((state_q == ST_IDLE) && bus.start) || (state_q == ST_FIN);
  assign cnt_adv   = handshake && !last_all;

  // Row-major order makes the next element's address the current one plus one.
  assign addr_cur = ADDR_W'(row) * ADDR_W'(OUT_COLS) + ADDR_W'(col);
  assign addr_d   = addr_cur + ADDR_W'(1);

  cnn_rc_counter #(
    .ROWS (OUT_ROWS),
    .COLS (OUT_COLS)
  ) u_rc_counter (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (cnt_clr),
    .adv_i      (cnt_adv),
    .row_o      (row),
    .col_o      (col),
    .last_col_o (last_col),
    .last_all_o (last_all)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      data_q       <= '0;
      m_valid_q    <= 1'b0;
      m_eol_q      <= 1'b0;
      m_last_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      rd_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            busy_q    <= 1'b1;
            rd_addr_q <= '0;
            rd_en_q   <= 1'b1;
            state_q   <= ST_RD;
          end
        end
        ST_RD: begin
          state_q <= ST_LAT;
        end
        ST_LAT: begin
          data_q    <= bus.rd_data;
          m_valid_q <= 1'b1;
          m_eol_q   <= last_col;
          m_last_q  <= last_all;
          state_q   <= ST_SEND;
        end
        ST_SEND: begin
          if (bus.m_ready) begin
            m_valid_q <= 1'b0;
            m_eol_q   <= 1'b0;
            m_last_q  <= 1'b0;
            if (m_last_q) begin
              state_q <= ST_FIN;
            end else begin
              rd_addr_q <= addr_d;
              rd_en_q   <= 1'b1;
              state_q   <= ST_RD;
            end
          end
        end
        ST_FIN: begin
          frame_done_q <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.rd_en      = rd_en_q;
  assign bus.rd_addr    = rd_addr_q;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_data     = data_q;
  assign bus.m_eol      = m_eol_q;
  assign bus.m_last     = m_last_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_cnn_result_streamer.sv
// Directed bench for cnn_result_streamer: a 4x4 instance and a 1x1 instance,
// each fed by a result-buffer model holding 100+address.
module tb_cnn_result_streamer;

  logic clk;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  cnn_result_streamer_if #(.DATA_W(16), .ADDR_W(4)) ifa ();
  cnn_result_streamer_if #(.DATA_W(16), .ADDR_W(1)) ifb ();

  cnn_result_streamer #(
    .DATA_W(16), .OUT_ROWS(4), .OUT_COLS(4), .ADDR_W(4)
  ) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.master)
  );

  cnn_result_streamer #(
    .DATA_W(16), .OUT_ROWS(1), .OUT_COLS(1), .ADDR_W(1)
  ) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ifa.rd_en) ifa.rd_data <= 16'(100 + 32'(ifa.rd_addr));
    if (ifb.rd_en) ifb.rd_data <= 16'(100 + 32'(ifb.rd_addr));
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Drives one or more frames on instance A and scoreboards every accepted beat.
  task automatic run_a(input int stall_beat, input int restart_beat, input bit fin_start,
                       input bit rnd, input int frames, input int exp_dur);
    int t, fst, beat, fbeat, frame, rdc, stall_left, first_v;
    bit holding, restarted, fin_flag, go;
    logic [15:0] held;
    stall_left = 5; restarted = 0; fin_flag = 0; go = 0; holding = 0; held = '0;
    beat = 0; fbeat = 0; frame = 0; rdc = 0; first_v = -1;
    ifa.m_ready = 1'b1;
    ifa.start = 1'b1;
    step;
    ifa.start = 1'b0;
    t = 1; fst = 0;
    chk("first_rd_en", 32'(ifa.rd_en), 32'd1);
    chk("first_rd_addr", 32'(ifa.rd_addr), 32'd0);
    chk("busy_after_start", 32'(ifa.busy), 32'd1);
    for (int c = 0; c < 3000 && frame < frames; c++) begin
      ifa.start = 1'b0;
      if (go) begin ifa.start = 1'b1; fst = t; go = 0; end
      if (fin_flag) begin ifa.start = 1'b1; fin_flag = 0; end
      if (ifa.rd_en) rdc++;
      if (ifa.frame_done) begin
        if (exp_dur > 0) chk("frame_done_cycle", 32'(t - fst), 32'(exp_dur));
        chk("beats_in_frame", 32'(fbeat), 32'd16);
        chk("busy_at_done", 32'(ifa.busy), 32'd0);
        frame++;
        fbeat = 0;
        if (frame < frames) go = 1;
      end
      if (ifa.m_valid) begin
        if (first_v < 0) first_v = t - fst;
        if (holding) chk("stall_data_stable", 32'(ifa.m_data), 32'(held));
        if (fbeat == stall_beat && stall_left > 0) begin
          stall_left--;
          ifa.m_ready = 1'b0;
          chk("stall_data", 32'(ifa.m_data), 32'(100 + stall_beat));
          chk("stall_no_rd_en", 32'(ifa.rd_en), 32'd0);
        end else begin
          ifa.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (fbeat == restart_beat && !restarted) begin
          ifa.start = 1'b1;
          restarted = 1;
        end
        if (ifa.m_ready) begin
          $display("beat %0d frame %0d data=%0d eol=%0b last=%0b",
                   fbeat, frame, ifa.m_data, ifa.m_eol, ifa.m_last);
          chk("beat_data", 32'(ifa.m_data), 32'(100 + fbeat));
          chk("beat_eol", 32'(ifa.m_eol), 32'(fbeat % 4 == 3));
          chk("beat_last", 32'(ifa.m_last), 32'(fbeat == 15));
          if (ifa.m_last && fin_start) fin_flag = 1;
          beat++;
          fbeat++;
          holding = 0;
        end else begin
          holding = 1;
          held = ifa.m_data;
        end
      end else if (rnd) begin
        ifa.m_ready = 1'($urandom_range(0, 1));
      end
      step;
      t++;
    end
    ifa.start = 1'b0;
    ifa.m_ready = 1'b1;
    chk("frames_completed", 32'(frame), 32'(frames));
    chk("total_beats", 32'(beat), 32'(16 * frames));
    chk("rd_en_count", 32'(rdc), 32'(16 * frames));
    chk("first_valid_latency", 32'(first_v), 32'd3);
    for (int i = 0; i < 4; i++) begin
      step;
      chk("idle_busy", 32'(ifa.busy), 32'd0);
      chk("idle_frame_done", 32'(ifa.frame_done), 32'd0);
    end
  endtask

  initial begin
    int  b;
    bit  found;
    rst = 1'b1;
    ifa.start = 1'b0; ifa.m_ready = 1'b0;
    ifb.start = 1'b0; ifb.m_ready = 1'b0;
    step;
    step;
    chk("rst_rd_en", 32'(ifa.rd_en), 32'd0);
    chk("rst_rd_addr", 32'(ifa.rd_addr), 32'd0);
    chk("rst_m_valid", 32'(ifa.m_valid), 32'd0);
    chk("rst_m_data", 32'(ifa.m_data), 32'd0);
    chk("rst_busy", 32'(ifa.busy), 32'd0);
    chk("rst_frame_done", 32'(ifa.frame_done), 32'd0);
    chk("rst_b_m_valid", 32'(ifb.m_valid), 32'd0);
    rst = 1'b0;
    step;

    // Full frame, m_ready always high
    run_a(-1, -1, 1'b0, 1'b0, 1, 50);
    // Five-cycle stall on beat 6
    run_a(6, -1, 1'b0, 1'b0, 1, 55);
    // start pulsed at beat 4 and during FIN must be ignored
    run_a(-1, 4, 1'b1, 1'b0, 1, 50);

    // Reset while beat 9 is presented
    ifa.m_ready = 1'b1;
    ifa.start = 1'b1;
    step;
    ifa.start = 1'b0;
    b = 0; found = 0;
    for (int c = 0; c < 200; c++) begin
      if (ifa.m_valid) begin
        if (b == 9) begin found = 1; break; end
        b++;
      end
      step;
    end
    chk("reach_beat9", 32'(found), 32'd1);
    chk("beat9_data", 32'(ifa.m_data), 32'd109);
    rst = 1'b1;
    #1;
    chk("midrst_m_valid", 32'(ifa.m_valid), 32'd0);
    chk("midrst_m_data", 32'(ifa.m_data), 32'd0);
    chk("midrst_busy", 32'(ifa.busy), 32'd0);
    chk("midrst_rd_addr", 32'(ifa.rd_addr), 32'd0);
    chk("midrst_m_eol", 32'(ifa.m_eol), 32'd0);
    step;
    rst = 1'b0;
    step;
    ifa.start = 1'b1;
    step;
    ifa.start = 1'b0;
    chk("restart_rd_en", 32'(ifa.rd_en), 32'd1);
    chk("restart_rd_addr", 32'(ifa.rd_addr), 32'd0);
    step;
    step;
    chk("restart_m_valid", 32'(ifa.m_valid), 32'd1);
    chk("restart_m_data", 32'(ifa.m_data), 32'd100);
    found = 0;
    for (int c = 0; c < 200; c++) begin
      step;
      if (ifa.frame_done) begin found = 1; break; end
    end
    chk("restart_frame_done", 32'(found), 32'd1);
    step;

    // 1x1 instance
    ifb.m_ready = 1'b1;
    ifb.start = 1'b1;
    step;
    ifb.start = 1'b0;
    chk("b_rd_en", 32'(ifb.rd_en), 32'd1);
    chk("b_rd_addr", 32'(ifb.rd_addr), 32'd0);
    step;
    step;
    $display("beat 0 1x1 data=%0d eol=%0b last=%0b", ifb.m_data, ifb.m_eol, ifb.m_last);
    chk("b_m_valid", 32'(ifb.m_valid), 32'd1);
    chk("b_m_data", 32'(ifb.m_data), 32'd100);
    chk("b_m_eol", 32'(ifb.m_eol), 32'd1);
    chk("b_m_last", 32'(ifb.m_last), 32'd1);
    step;
    chk("b_fin_valid", 32'(ifb.m_valid), 32'd0);
    chk("b_fin_frame_done", 32'(ifb.frame_done), 32'd0);
    chk("b_fin_busy", 32'(ifb.busy), 32'd1);
    step;
    chk("b_frame_done", 32'(ifb.frame_done), 32'd1);
    chk("b_done_busy", 32'(ifb.busy), 32'd0);
    step;
    chk("b_frame_done_pulse", 32'(ifb.frame_done), 32'd0);

    // Three back-to-back frames with random m_ready
    run_a(-1, -1, 1'b0, 1'b1, 3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
